load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 52 +++++
 rtl/lsu_align.sv | 64 ++++++
 rtl/load_store_unit.sv | 135 +++++++++++++
 tb/tb_load_store_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared load/store unit definitions: width codes, FSM states, legality helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package lsu_pkg;

  localparam int DEFAULT_READ_LATENCY = 2;

  // RV32I load/store width codes (funct3)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } lsu_state_t;

  // Unsigned widths exist only for loads.
  function automatic logic funct3_legal(input logic write, input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !write;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Snap a byte offset down to the natural alignment of the access width.
  function automatic logic [1:0] align_offset(input logic [2:0] f3, input logic [1:0] off);
    logic [1:0] r;
    case (f3[1:0])
      2'b01:   r = {off[1], 1'b0};
      2'b10:   r = 2'b00;
      default: r = off;
    endcase
    return r;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic m;
    case (f3[1:0])
      2'b01:   m = off[0];
      2'b10:   m = (off != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic: store strobes and steering, load byte/half extraction and extension.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake, outputs follow inputs.
// Ports: st_* describe the store being issued (offset already aligned),
//        ld_* describe the load being completed and the raw memory word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_offset,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_strobe,
  output logic [31:0] st_data,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_offset,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_result
);

  logic [31:0] ld_shifted;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_strobe = 4'b0000;
    st_data   = 32'h0;
    case (st_funct3[1:0])
      2'b00: begin
        st_strobe = 4'b0001 << st_offset;
        st_data   = {24'h0, st_wdata[7:0]} << {st_offset, 3'b000};
      end
      2'b01: begin
        st_strobe = 4'b0011 << st_offset;
        st_data   = {16'h0, st_wdata[15:0]} << {st_offset, 3'b000};
      end
      2'b10: begin
        st_strobe = 4'b1111;
        st_data   = st_wdata;
      end
      default: begin
        st_strobe = 4'b0000;
        st_data   = 32'h0;
      end
    endcase
  end

  // Shift the addressed lane down to bit 0; halves arrive with an even offset.
  assign ld_shifted = ld_word >> {ld_offset, 3'b000};
  assign ld_byte    = ld_shifted[7:0];
  assign ld_half    = ld_shifted[15:0];

  always_comb begin
    ld_result = 32'h0;
    case (ld_funct3)
      F3_B:    ld_result = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    ld_result = {{16{ld_half[15]}}, ld_half};
      F3_W:    ld_result = ld_word;
      F3_BU:   ld_result = {24'h0, ld_byte};
      F3_HU:   ld_result = {16'h0, ld_half};
      default: ld_result = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding RV32I load/store unit between the core and memory control.
// Latency: store/error respond 1 cycle after accept, loads READ_LATENCY+1 cycles after accept.
// Backpressure: req_ready only in IDLE; it rises with resp_valid so back-to-back issue has no gap.
// Option: define MISALIGNED_TRAP_EN to reject misaligned H/W accesses instead of truncating them.
// Ports: req_* core request, resp_* one-cycle completion, mem_* memory-control side.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int READ_LATENCY = DEFAULT_READ_LATENCY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [3:0]  mem_write_enable,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  localparam int CW = (READ_LATENCY >= 1) ? $clog2(READ_LATENCY + 1) : 1;

  lsu_state_t  state, state_next;
  logic [CW-1:0] cnt;
  logic        accept, done;

  logic        acc_write, acc_err;
  logic [2:0]  acc_funct3;
  logic [1:0]  acc_offset;

  logic        req_err;
  logic [1:0]  req_offset;
  logic [3:0]  st_strobe;
  logic [31:0] st_data;
  logic [31:0] ld_result;

  assign req_offset = align_offset(req_funct3, req_address[1:0]);

`ifdef MISALIGNED_TRAP_EN
  assign req_err = !funct3_legal(req_write, req_funct3) ||
                   misaligned(req_funct3, req_address[1:0]);
`else
  assign req_err = !funct3_legal(req_write, req_funct3);
`endif

  lsu_align u_align (
    .st_funct3 (req_funct3),
    .st_offset (req_offset),
    .st_wdata  (req_wdata),
    .st_strobe (st_strobe),
    .st_data   (st_data),
    .ld_funct3 (acc_funct3),
    .ld_offset (acc_offset),
    .ld_word   (mem_data_out),
    .ld_result (ld_result)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    done       = 1'b0;
    req_ready  = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept     = 1'b1;
          state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt == '0) begin
          done       = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt              <= '0;
      acc_write        <= 1'b0;
      acc_err          <= 1'b0;
      acc_funct3       <= 3'b000;
      acc_offset       <= 2'b00;
      resp_valid       <= 1'b0;
      resp_rdata       <= 32'h0;
      resp_error       <= 1'b0;
      mem_write_enable <= 4'b0000;
      mem_address      <= 32'h0;
      mem_data_in      <= 32'h0;
    end else begin
      // Strobes and response fields are single-cycle pulses.
      resp_valid       <= 1'b0;
      resp_rdata       <= 32'h0;
      resp_error       <= 1'b0;
      mem_write_enable <= 4'b0000;

      if (accept) begin
        mem_address      <= {req_address[31:2], 2'b00};
        mem_data_in      <= st_data;
        mem_write_enable <= (req_write && !req_err) ? st_strobe : 4'b0000;
        acc_write        <= req_write;
        acc_err          <= req_err;
        acc_funct3       <= req_funct3;
        acc_offset       <= req_offset;
        // Only legal loads wait on the memory pipeline.
        cnt              <= (req_write || req_err) ? '0 : CW'(READ_LATENCY);
      end else if (state == ST_ACCESS && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end

      if (done) begin
        resp_valid <= 1'b1;
        resp_error <= acc_err;
        resp_rdata <= (acc_write || acc_err) ? 32'h0 : ld_result;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int RL = DEFAULT_READ_LATENCY;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_address;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [3:0]  mem_write_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.READ_LATENCY(RL)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_funct3       (req_funct3),
    .req_address      (req_address),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_error       (resp_error),
    .mem_write_enable (mem_write_enable),
    .mem_address      (mem_address),
    .mem_data_in      (mem_data_in),
    .mem_data_out     (mem_data_out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Present one request for a single edge, then withdraw it.
  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    req_valid   = 1'b1;
    req_write   = w;
    req_funct3  = f3;
    req_address = a;
    req_wdata   = d;
    step();
    req_valid   = 1'b0;
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] exp_we,
                          input logic [31:0] exp_data, input logic exp_err);
    issue(1'b1, f3, a, d);
    chk({tag, "_we"}, {28'h0, mem_write_enable}, {28'h0, exp_we});
    if (!exp_err) chk({tag, "_data"}, mem_data_in, exp_data);
    chk({tag, "_addr"}, mem_address, {a[31:2], 2'b00});
    chk({tag, "_busy"}, {31'h0, req_ready}, 32'h0);
    step();
    chk({tag, "_we_clr"}, {28'h0, mem_write_enable}, 32'h0);
    chk({tag, "_rv"}, {31'h0, resp_valid}, 32'h1);
    chk({tag, "_err"}, {31'h0, resp_error}, {31'h0, exp_err});
    chk({tag, "_rdata"}, resp_rdata, 32'h0);
    step();
    chk({tag, "_rv_drop"}, {31'h0, resp_valid}, 32'h0);
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] word, input logic [31:0] exp_rd, input logic exp_err);
    mem_data_out = word;
    issue(1'b0, f3, a, 32'h0);
    if (exp_err) begin
      chk({tag, "_we"}, {28'h0, mem_write_enable}, 32'h0);
      step();
    end else begin
      chk({tag, "_addr"}, mem_address, {a[31:2], 2'b00});
      for (int i = 0; i <= RL; i++) begin
        chk({tag, "_wait"}, {31'h0, resp_valid}, 32'h0);
        chk({tag, "_we"}, {28'h0, mem_write_enable}, 32'h0);
        step();
      end
    end
    chk({tag, "_rv"}, {31'h0, resp_valid}, 32'h1);
    chk({tag, "_err"}, {31'h0, resp_error}, {31'h0, exp_err});
    chk({tag, "_rdata"}, resp_rdata, exp_rd);
    chk({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
    step();
    chk({tag, "_rv_drop"}, {31'h0, resp_valid}, 32'h0);
    chk({tag, "_rd_zero"}, resp_rdata, 32'h0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_funct3   = 3'b000;
    req_address  = 32'h0;
    req_wdata    = 32'h0;
    mem_data_out = 32'h0;
    step();
    step();
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_rv",    {31'h0, resp_valid}, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err",   {31'h0, resp_error}, 32'h0);
    chk("rst_we",    {28'h0, mem_write_enable}, 32'h0);
    chk("rst_addr",  mem_address, 32'h0);
    chk("rst_din",   mem_data_in, 32'h0);
    reset = 1'b0;
    step();

    // Stores: lane strobes and steered data
    do_store("sb3", F3_B, 32'h0100_0003, 32'h0000_00AB, 4'b1000, 32'hAB00_0000, 1'b0);
    do_store("sh2", F3_H, 32'h0100_0002, 32'h1234_BEEF, 4'b1100, 32'hBEEF_0000, 1'b0);
    do_store("sw",  F3_W, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 1'b0);
    do_store("sb1", F3_B, 32'h0000_0021, 32'h0000_0077, 4'b0010, 32'h0000_7700, 1'b0);
    do_store("sbu_ill", F3_BU, 32'h0000_0030, 32'h0000_0055, 4'b0000, 32'h0, 1'b1);

    // Loads: extraction and extension
    do_load("lb",  F3_B,  32'h0100_0002, 32'h00F0_0000, 32'hFFFF_FFF0, 1'b0);
    do_load("lbu", F3_BU, 32'h0100_0002, 32'h00F0_0000, 32'h0000_00F0, 1'b0);
    do_load("lhu", F3_HU, 32'h0000_0042, 32'h8001_1234, 32'h0000_8001, 1'b0);
    do_load("lh",  F3_H,  32'h0000_0040, 32'h0000_9abc, 32'hFFFF_9ABC, 1'b0);
    do_load("lw",  F3_W,  32'h0000_0044, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0);
    do_load("l111", 3'b111, 32'h0000_0048, 32'h1234_5678, 32'h0, 1'b1);
`ifdef MISALIGNED_TRAP_EN
    do_load("lh_mis", F3_H, 32'h0100_0001, 32'h1234_8001, 32'h0, 1'b1);
`else
    do_load("lh_mis", F3_H, 32'h0100_0001, 32'h1234_8001, 32'hFFFF_8001, 1'b0);
`endif

    // Back-to-back loads with req_valid held high
    mem_data_out = 32'h1122_3344;
    req_valid   = 1'b1;
    req_write   = 1'b0;
    req_funct3  = F3_W;
    req_address = 32'h0000_0020;
    step();
    chk("b2b_busy", {31'h0, req_ready}, 32'h0);
    for (int i = 0; i < RL; i++) step();
    step();
    chk("b2b_rv1",    {31'h0, resp_valid}, 32'h1);
    chk("b2b_rd1",    resp_rdata, 32'h1122_3344);
    chk("b2b_ready1", {31'h0, req_ready}, 32'h1);
    req_address  = 32'h0000_0024;
    mem_data_out = 32'h5566_7788;
    step();
    req_valid = 1'b0;
    chk("b2b_accept2", mem_address, 32'h0000_0024);
    chk("b2b_busy2",   {31'h0, req_ready}, 32'h0);
    chk("b2b_rv_gap",  {31'h0, resp_valid}, 32'h0);
    for (int i = 0; i < RL; i++) step();
    step();
    chk("b2b_rv2", {31'h0, resp_valid}, 32'h1);
    chk("b2b_rd2", resp_rdata, 32'h5566_7788);
    step();

    // Reset during the store strobe cycle aborts the access
    issue(1'b1, F3_W, 32'h0000_0050, 32'hA5A5_A5A5);
    chk("rstmid_we_pre", {28'h0, mem_write_enable}, 32'hF);
    reset = 1'b1;
    step();
    chk("rstmid_we",    {28'h0, mem_write_enable}, 32'h0);
    chk("rstmid_rv",    {31'h0, resp_valid}, 32'h0);
    chk("rstmid_ready", {31'h0, req_ready}, 32'h1);
    chk("rstmid_addr",  mem_address, 32'h0);
    reset = 1'b0;
    step();
    chk("rstmid_rv_after", {31'h0, resp_valid}, 32'h0);
    step();
    chk("rstmid_rv_after2", {31'h0, resp_valid}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
